// File: rtl/mc_seq_pkg.sv
// rtl/mc_seq_pkg.sv - shared types and constants for the multicycle sequencer
package mc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4,
    HALT  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_ALW  = 2'b01,
    BR_GT   = 2'b10,
    BR_EQ   = 2'b11
  } br_e;

  localparam int F_GT  = 0;
  localparam int F_EQ  = 1;
  localparam int F_CO  = 2;
  localparam int F_SCO = 3;

endpackage

// File: rtl/seq_flags.sv
// rtl/seq_flags.sv - 4-bit status flag register, clear beats capture
module seq_flags (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       we,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   flags_q <= '0;
    else if (clr) flags_q <= '0;
    else if (we)  flags_q <= d;
  end

  assign q = flags_q;

endmodule

// File: rtl/mc_seq_ctrl.sv
// rtl/mc_seq_ctrl.sv - FETCH/EXEC/MEM/WB program sequencer with PC, flags and dmem timeout
module mc_seq_ctrl
  import mc_seq_pkg::*;
#(
  parameter int              PC_W       = 12,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int              MEM_TO     = 16
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            start,
  output logic [PC_W-1:0] pc,
  output logic            fetch_req,
  input  logic            instr_valid,
  input  logic [1:0]      dec_br,
  input  logic [PC_W-1:0] jump_tgt,
  input  logic            dec_wen_r,
  input  logic            dec_load,
  input  logic            dec_store,
  input  logic            dec_done,
  input  logic            dec_flag_we,
  input  logic            dec_flag_clr,
  input  logic            alu_gt,
  input  logic            alu_eq,
  input  logic            alu_co,
  input  logic            alu_sco,
  output logic [3:0]      flags,
  output logic            wen_r,
  output logic            mem_req,
  output logic            wen_d,
  input  logic            mem_ack,
  output logic            busy,
  output logic            done,
  output logic            mem_err
);

  localparam int TO_W = $clog2(MEM_TO + 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            store_q, store_d;
  logic [TO_W-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;
  logic            flag_clr, flag_we, taken;
  logic [3:0]      alu_vec;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
      store_q <= 1'b0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      store_q <= store_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Branch decision sees the flags as they stood before this EXEC's update.
  always_comb begin
    alu_vec        = '0;
    alu_vec[F_GT]  = alu_gt;
    alu_vec[F_EQ]  = alu_eq;
    alu_vec[F_CO]  = alu_co;
    alu_vec[F_SCO] = alu_sco;
    case (br_e'(dec_br))
      BR_ALW:  taken = 1'b1;
      BR_GT:   taken = flags[F_GT];
      BR_EQ:   taken = flags[F_EQ];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    store_d   = store_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    fetch_req = 1'b0;
    wen_r     = 1'b0;
    mem_req   = 1'b0;
    wen_d     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    flag_clr  = 1'b0;
    flag_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = START_ADDR;
        end
      end
      FETCH: begin
        fetch_req = 1'b1;
        busy      = 1'b1;
        if (instr_valid) state_d = EXEC;
      end
      EXEC: begin
        busy = 1'b1;
        if (dec_done) begin
          state_d = HALT;
        end else begin
          flag_clr = dec_flag_clr;
          flag_we  = dec_flag_we;
          if (dec_load || dec_store) begin
            state_d = MEM;
            store_d = dec_store;
            tmo_d   = '0;
          end else begin
            wen_r   = dec_wen_r;
            pc_d    = taken ? jump_tgt : pc_q + PC_W'(1);
            state_d = FETCH;
          end
        end
      end
      MEM: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        wen_d   = store_q;
        if (mem_ack) begin
          if (store_q) begin
            pc_d    = pc_q + PC_W'(1);
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (tmo_q == TO_W'(MEM_TO - 1)) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else begin
          tmo_d = tmo_q + TO_W'(1);
        end
      end
      WB: begin
        busy    = 1'b1;
        wen_r   = 1'b1;
        pc_d    = pc_q + PC_W'(1);
        state_d = FETCH;
      end
      HALT: begin
        done = 1'b1;
        if (start) begin
          state_d = FETCH;
          pc_d    = START_ADDR;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  seq_flags u_flags (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (flag_clr),
    .we    (flag_we),
    .d     (alu_vec),
    .q     (flags)
  );

  assign pc      = pc_q;
  assign mem_err = err_q;

endmodule
